// File: rtl/capture_pkg.sv
// Shared defaults and helpers for the strobe-captured word FIFO.
// The optional drop counter is enabled by defining CAPTURE_DROP_CNT_EN.
package capture_pkg;

    localparam int DATA_W_DEF      = 6;
    localparam int DEPTH_DEF       = 4;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int DROP_CNT_W      = 8;

    typedef logic [DATA_W_DEF-1:0] word_t;

    // Saturating increment for the drop counter; sticks at all-ones.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] value);
        logic [DROP_CNT_W-1:0] result;
        if (value == {DROP_CNT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

endpackage

// File: rtl/capture_word_fifo_sync.sv
// Strobe synchroniser plus rising-edge detector. All flops reset to ones so a
// strobe held at either level across reset never reads as a fresh rising edge.
module strobe_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_pulse
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;

    // Synchroniser chain and one-cycle-delayed copy of its output for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b1}};
            prev_r <= 1'b1;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign rise_pulse = sync_r[SYNC_STAGES-1] & ~prev_r;

endmodule

// File: rtl/capture_word_fifo.sv
// Takes the upstream capture register's word into the clk domain on each strobe rising
// edge and buffers it in a first-word-fall-through FIFO. Optional: CAPTURE_DROP_CNT_EN.
module capture_word_fifo
    import capture_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cap_strobe,
    input  logic [DATA_W-1:0]       cap_data,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    ovf,
    input  logic                    ovf_clr,
    output logic [DROP_CNT_W-1:0]   drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic                push_s;
    logic                pop_s;
    logic                full_s;
    logic                wr_en_s;
    logic                drop_s;
    logic [LVL_W-1:0]    level_nxt_s;
    logic [PTR_W-1:0]    rd_ptr_nxt_s;
    logic [DATA_W-1:0]   head_nxt_s;

    logic [DATA_W-1:0]   mem_r [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [LVL_W-1:0]    level_r;
    logic                out_valid_r;
    logic [DATA_W-1:0]   out_data_r;
    logic                ovf_r;

    // cap_data is taken unsynchronised: it settled well before the synchronised edge appears
    strobe_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_strobe_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_in   (cap_strobe),
        .rise_pulse (push_s)
    );

    // Push/pop arbitration: a pop on a full FIFO frees the slot the same cycle's push needs
    always_comb begin
        full_s  = (level_r == FULL_LVL);
        pop_s   = out_valid_r & out_ready;
        wr_en_s = push_s & (~full_s | pop_s);
        drop_s  = push_s & full_s & ~pop_s;
    end

    // Next occupancy and read pointer
    always_comb begin
        level_nxt_s  = level_r;
        rd_ptr_nxt_s = rd_ptr_r;
        case ({wr_en_s, pop_s})
            2'b10:   level_nxt_s = level_r + LVL_W'(1);
            2'b01:   level_nxt_s = level_r - LVL_W'(1);
            default: level_nxt_s = level_r;
        endcase
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
    end

    // Next head word; bypasses the array when the word being written becomes the head
    always_comb begin
        head_nxt_s = {DATA_W{1'b0}};
        if (level_nxt_s == LVL_W'(0)) begin
            head_nxt_s = {DATA_W{1'b0}};
        end else if (wr_en_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = cap_data;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Storage array write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_r[wr_ptr_r] <= cap_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers, level and registered output port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= PTR_W'(0);
            rd_ptr_r    <= PTR_W'(0);
            level_r     <= LVL_W'(0);
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            rd_ptr_r    <= rd_ptr_nxt_s;
            level_r     <= level_nxt_s;
            out_valid_r <= (level_nxt_s != LVL_W'(0));
            out_data_r  <= head_nxt_s;
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else if (ovf_clr) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

`ifdef CAPTURE_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_r;

    // Saturating drop counter; a drop coinciding with a clear restarts the count at one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_r <= {DROP_CNT_W{1'b0}};
        end else if (drop_s && ovf_clr) begin
            drop_cnt_r <= DROP_CNT_W'(1);
        end else if (drop_s) begin
            drop_cnt_r <= sat_inc(drop_cnt_r);
        end else if (ovf_clr) begin
            drop_cnt_r <= {DROP_CNT_W{1'b0}};
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign drop_cnt = drop_cnt_r;
`else
    assign drop_cnt = {DROP_CNT_W{1'b0}};
`endif

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign level     = level_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_capture_word_fifo.sv
// Randomised scoreboard bench for capture_word_fifo with a queue-based reference model.
module tb_capture_word_fifo;
    import capture_pkg::*;

    localparam int DW    = 6;
    localparam int DEP   = 4;
    localparam int SYNC  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cap_strobe;
    logic [DW-1:0] cap_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [2:0]    level;
    logic          ovf;
    logic          ovf_clr;
    logic [7:0]    drop_cnt;

    capture_word_fifo #(.DATA_W(DW), .DEPTH(DEP), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .cap_strobe(cap_strobe), .cap_data(cap_data),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .level(level), .ovf(ovf), .ovf_clr(ovf_clr), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int    passed = 0;
    int    total  = 0;
    word_t exp_q[$];
    int    rd_idx = 0;
    int    hi_cnt = 99;
    logic  m_ovf  = 1'b0;
    int    m_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int occ();
        return exp_q.size() - rd_idx;
    endfunction

    function automatic int exp_drop_cnt();
`ifdef CAPTURE_DROP_CNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    // Reference model: a word is captured on the (SYNC+1)-th edge that sees the strobe high
    initial begin : model
        bit cap;
        bit drop;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_ovf  = 1'b0;
                m_cnt  = 0;
                hi_cnt = 99;
            end else begin
                if (!cap_strobe) hi_cnt = 0;
                else if (hi_cnt < 99) hi_cnt++;
                cap  = (hi_cnt == SYNC + 1);
                drop = 1'b0;
                if (cap) begin
                    if (occ() >= DEP) drop = 1'b1;
                    else exp_q.push_back(cap_data);
                end
                if (drop) begin
                    m_ovf = 1'b1;
                    m_cnt = ovf_clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
                end else if (ovf_clr) begin
                    m_ovf = 1'b0;
                    m_cnt = 0;
                end
            end
        end
    end

    // Monitor: compares presented outputs with the model and retires accepted words
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rd_idx = exp_q.size();
            end else begin
                chk("level", 32'(level), 32'(occ()));
                chk("out_valid", 32'(out_valid), 32'(occ() != 0));
                if (occ() != 0) chk("out_data", 32'(out_data), 32'(exp_q[rd_idx]));
                else chk("out_data_idle", 32'(out_data), 32'd0);
                chk("ovf", 32'(ovf), 32'(m_ovf));
                chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop_cnt()));
                if (occ() != 0 && out_ready) rd_idx++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse(input logic [DW-1:0] w, input int hi, input int lo);
        cap_data   = w;
        cap_strobe = 1'b1;
        repeat (hi) cyc();
        cap_strobe = 1'b0;
        repeat (lo) cyc();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_n = 1'b0; cap_strobe = 1'b1; cap_data = 6'h00; out_ready = 1'b0; ovf_clr = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (10) cyc();
        chk("reset_hold_level", 32'(level), 32'd0);
        chk("reset_hold_valid", 32'(out_valid), 32'd0);

        // First capture latency with consumer stalled
        cap_strobe = 1'b0;
        repeat (4) cyc();
        cap_data = 6'h2A; cap_strobe = 1'b1;
        cyc(); chk("lat_edge1_valid", 32'(out_valid), 32'd0);
        cyc(); chk("lat_edge2_valid", 32'(out_valid), 32'd0);
        cyc(); chk("lat_edge3_valid", 32'(out_valid), 32'd1);
        chk("lat_data", 32'(out_data), 32'h2A);
        chk("lat_level", 32'(level), 32'd1);
        cyc(); cap_strobe = 1'b0;
        repeat (4) cyc();
        out_ready = 1'b1; repeat (3) cyc(); out_ready = 1'b0;

        // Fill then overflow
        for (int i = 1; i <= 4; i++) pulse(DW'(i), 3, 3);
        pulse(6'h05, 3, 3);
        chk("ovf_level", 32'(level), 32'd4);
        chk("ovf_set", 32'(ovf), 32'd1);
        out_ready = 1'b1; repeat (6) cyc(); out_ready = 1'b0;
        ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(ovf), 32'd0);
        chk("cnt_cleared", 32'(drop_cnt), 32'd0);

        // Full, then capture edge coincides with a pop
        for (int i = 1; i <= 4; i++) pulse(DW'(i), 3, 3);
        cap_data = 6'h05; cap_strobe = 1'b1;
        cyc(); cyc(); out_ready = 1'b1;
        cyc(); out_ready = 1'b0;
        chk("coinc_level", 32'(level), 32'd4);
        chk("coinc_ovf", 32'(ovf), 32'd0);
        cap_strobe = 1'b0; repeat (3) cyc();
        out_ready = 1'b1; repeat (6) cyc(); out_ready = 1'b0;

        // Many drops saturate the counter
        for (int i = 0; i < 4; i++) pulse(DW'($urandom), 3, 3);
        for (int i = 0; i < 300; i++) pulse(DW'($urandom), 3, 3);
`ifdef CAPTURE_DROP_CNT_EN
        chk("cnt_saturated", 32'(drop_cnt), 32'd255);
`else
        chk("cnt_tied_zero", 32'(drop_cnt), 32'd0);
`endif
        ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;
        chk("sat_cleared", 32'(drop_cnt), 32'd0);

        // Random traffic, consumer back-pressure and clear pulses
        for (int n = 0; n < 150; n++) begin
            int hi = $urandom_range(3, 6);
            int lo = $urandom_range(3, 6);
            cap_data   = DW'($urandom);
            cap_strobe = 1'b1;
            for (int c = 0; c < hi + lo; c++) begin
                if (c == hi) cap_strobe = 1'b0;
                out_ready = ($urandom_range(0, 2) == 0);
                ovf_clr   = ($urandom_range(0, 11) == 0);
                cyc();
            end
        end
        ovf_clr = 1'b0;

        // Reset mid-stream discards buffered words immediately
        out_ready = 1'b0;
        pulse(6'h11, 3, 3);
        pulse(6'h22, 3, 3);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_level", 32'(level), 32'd0);
        chk("midrst_data", 32'(out_data), 32'd0);
        repeat (3) cyc();
        rst_n = 1'b1;
        repeat (3) cyc();
        pulse(6'h33, 3, 3);
        out_ready = 1'b1; repeat (4) cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
